data_cache_emu: RTL

DATA_CACHE_EMU -- requirements
Module: data_cache_emu

---
 rtl/dce_pkg.sv | 12 +
 rtl/data_cache_emu_if.sv | 35 +++
 rtl/dce_mem.sv | 19 +
 rtl/data_cache_emu.sv | 118 +++++++++++
 4 files changed

// File: rtl/dce_pkg.sv
// Shared types and sizing for the data cache emulator (FSM states, tag widths, default load latency).
package dce_pkg;
  localparam int unsigned ROB_TAG_W      = 5;
  localparam int unsigned PHY_ADDR_W     = 6;
  localparam int unsigned LW_LATENCY_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } dce_state_e;
endpackage

// File: rtl/data_cache_emu_if.sv
// Issue / flush / commit / completion bundle between the LSQ-ROB side (master) and the data cache emulator (slave).
interface data_cache_emu_if;
  import dce_pkg::*;

  logic                  Iss_LdStReady;
  logic                  Iss_LdStOpcode;
  logic [ROB_TAG_W-1:0]  Iss_LdStRobTag;
  logic [31:0]           Iss_LdStAddr;
  logic [PHY_ADDR_W-1:0] Iss_LdStPhyAddr;
  logic                  Cdb_Flush;
  logic [ROB_TAG_W-1:0]  Rob_TopPtr;
  logic [ROB_TAG_W-1:0]  Cdb_RobDepth;
  logic                  Rob_CommitMemWrite;
  logic [31:0]           Rob_SwAddr;
  logic [31:0]           Rf_SwData;
  logic                  DCE_ReadBusy;
  logic                  DCE_ReadDone;
  logic [PHY_ADDR_W-1:0] DCE_PhyAddr;
  logic                  DCE_Opcode;
  logic [ROB_TAG_W-1:0]  DCE_RobTag;
  logic [31:0]           DCE_Addr;
  logic [31:0]           DCE_MemData;

  modport master (
    output Iss_LdStReady, Iss_LdStOpcode, Iss_LdStRobTag, Iss_LdStAddr, Iss_LdStPhyAddr,
    output Cdb_Flush, Rob_TopPtr, Cdb_RobDepth, Rob_CommitMemWrite, Rob_SwAddr, Rf_SwData,
    input  DCE_ReadBusy, DCE_ReadDone, DCE_PhyAddr, DCE_Opcode, DCE_RobTag, DCE_Addr, DCE_MemData
  );

  modport slave (
    input  Iss_LdStReady, Iss_LdStOpcode, Iss_LdStRobTag, Iss_LdStAddr, Iss_LdStPhyAddr,
    input  Cdb_Flush, Rob_TopPtr, Cdb_RobDepth, Rob_CommitMemWrite, Rob_SwAddr, Rf_SwData,
    output DCE_ReadBusy, DCE_ReadDone, DCE_PhyAddr, DCE_Opcode, DCE_RobTag, DCE_Addr, DCE_MemData
  );
endinterface

// File: rtl/dce_mem.sv
// Word-addressed data memory: combinational read port, posedge write port, contents never reset.
module dce_mem #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic                         Clk,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] waddr,
  input  logic [31:0]                  wdata,
  input  logic [$clog2(MEM_WORDS)-1:0] raddr,
  output logic [31:0]                  rdata
);
  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/data_cache_emu.sv
// Single-outstanding load emulator with fixed miss latency and ROB-relative flush kill.
// Optional hit model (8-entry direct-mapped tags) enabled by defining DCE_HIT_MODEL_EN.
module data_cache_emu
  import dce_pkg::*;
#(
  parameter int unsigned LW_LATENCY = LW_LATENCY_DEF,
  parameter int unsigned MEM_WORDS  = 256
) (
  input  logic             Clk,
  input  logic             Reset,
  data_cache_emu_if.slave  bus
);
  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam logic [3:0]  LAT_LOAD = 4'(LW_LATENCY - 1);

  dce_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ROB_TAG_W-1:0]  tag_q;
  logic [31:0]           addr_q;
  logic [PHY_ADDR_W-1:0] phy_q;
  logic                  op_q;
  logic                  accept, kill, hit;
  logic [ROB_TAG_W-1:0]  rel_age;
  logic                  unused_sw_bits;

  // Age of the in-flight load relative to the ROB head wraps modulo 32.
  assign rel_age = tag_q - bus.Rob_TopPtr;
  assign kill    = bus.Cdb_Flush && (rel_age > bus.Cdb_RobDepth);
  assign accept  = (state_q == S_IDLE) && bus.Iss_LdStReady && bus.Iss_LdStOpcode;

`ifdef DCE_HIT_MODEL_EN
  logic [26:0] tag_arr [8];
  logic [7:0]  valid_q;
  logic [2:0]  iss_idx;

  assign iss_idx = bus.Iss_LdStAddr[4:2];
  assign hit     = valid_q[iss_idx] && (tag_arr[iss_idx] == bus.Iss_LdStAddr[31:5]);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= '0;
    end else if (bus.DCE_ReadDone) begin
      valid_q[addr_q[4:2]] <= 1'b1;
      tag_arr[addr_q[4:2]] <= addr_q[31:5];
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (hit) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (kill) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      addr_q  <= '0;
      phy_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        tag_q  <= bus.Iss_LdStRobTag;
        addr_q <= bus.Iss_LdStAddr;
        phy_q  <= bus.Iss_LdStPhyAddr;
        op_q   <= 1'b1;
      end
    end
  end

  assign bus.DCE_ReadBusy = (state_q != S_IDLE);
  assign bus.DCE_ReadDone = (state_q == S_DONE) && !kill;
  assign bus.DCE_RobTag   = tag_q;
  assign bus.DCE_Addr     = addr_q;
  assign bus.DCE_PhyAddr  = phy_q;
  assign bus.DCE_Opcode   = op_q;

  // Byte-offset and aliasing upper store-address bits do not select a word.
  assign unused_sw_bits = ^{bus.Rob_SwAddr[31:AW+2], bus.Rob_SwAddr[1:0]};

  dce_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .Clk   (Clk),
    .we    (bus.Rob_CommitMemWrite && !Reset),
    .waddr (bus.Rob_SwAddr[AW+1:2]),
    .wdata (bus.Rf_SwData),
    .raddr (addr_q[AW+1:2]),
    .rdata (bus.DCE_MemData)
  );
endmodule
